// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and default phase durations for the
// intersection scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_MAIN_G  = 3'd0,
    S_MAIN_Y  = 3'd1,
    S_RED_A   = 3'd2,
    S_CROSS_G = 3'd3,
    S_CROSS_Y = 3'd4,
    S_RED_B   = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  localparam int DEF_MAIN_MIN_G = 15;
  localparam int DEF_MAIN_Y     = 3;
  localparam int DEF_CROSS_G    = 10;
  localparam int DEF_CROSS_Y    = 3;
  localparam int DEF_ALL_RED    = 1;
  localparam int DEF_CNT_W      = 5;

  // {main, cross} lamp pair shown while in state s
  function automatic logic [5:0] lamps(state_t s);
    case (s)
      S_MAIN_G:  return {LAMP_G, LAMP_R};
      S_MAIN_Y:  return {LAMP_Y, LAMP_R};
      S_CROSS_G: return {LAMP_R, LAMP_G};
      S_CROSS_Y: return {LAMP_R, LAMP_Y};
      default:   return {LAMP_R, LAMP_R};
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled phase counter with synchronous clear; optionally saturates at
// the terminal value instead of running past it.
module phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             tick,
  input  logic             clr,
  input  logic             sat_en,
  input  logic [CNT_W-1:0] term,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;
  logic             at_term;

  assign at_term = (cnt == term);
  assign expire  = tick && at_term;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)                        cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (tick && !(sat_en && at_term)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-driven main/cross phase scheduler: main rests green, cross is served
// on latched requests, all-red clearance between roads, preempt favours main.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int MAIN_MIN_G = DEF_MAIN_MIN_G,
  parameter int MAIN_Y     = DEF_MAIN_Y,
  parameter int CROSS_G    = DEF_CROSS_G,
  parameter int CROSS_Y    = DEF_CROSS_Y,
  parameter int ALL_RED    = DEF_ALL_RED,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       tick,
  input  logic       cross_req,
  input  logic       ped_req,
  input  logic       preempt,
  output logic [2:0] main_st,
  output logic [2:0] cross_st,
  output logic       ped_walk,
  output logic [2:0] phase,
  output logic       req_pending
);

  state_t           state, state_n;
  logic [CNT_W-1:0] term;
  logic             expire, clr, entering;
  logic             veh_lat, ped_lat;

  assign req_pending = veh_lat | ped_lat;
  assign phase       = state;
  assign clr         = (state_n != state);
  assign entering    = (state_n == S_CROSS_G) && (state != S_CROSS_G);

  always_comb begin
    term = '0;
    case (state)
      S_MAIN_G:  term = CNT_W'(MAIN_MIN_G - 1);
      S_MAIN_Y:  term = CNT_W'(MAIN_Y - 1);
      S_CROSS_G: term = CNT_W'(CROSS_G - 1);
      S_CROSS_Y: term = CNT_W'(CROSS_Y - 1);
      default:   term = CNT_W'(ALL_RED - 1);
    endcase
  end

  // In MAIN_G the counter parks at its terminal value, so expire there means
  // "minimum green served and a tick arrived".
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .tick   (tick),
    .clr    (clr),
    .sat_en (state == S_MAIN_G),
    .term   (term),
    .expire (expire)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= S_MAIN_G;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_MAIN_G:  if (expire && req_pending && !preempt) state_n = S_MAIN_Y;
      S_MAIN_Y:  if (expire) state_n = S_RED_A;
      S_RED_A:   if (expire) state_n = preempt ? S_MAIN_G : S_CROSS_G;
      S_CROSS_G: if (expire || (tick && preempt)) state_n = S_CROSS_Y;
      S_CROSS_Y: if (expire) state_n = S_RED_B;
      S_RED_B:   if (expire) state_n = S_MAIN_G;
      default:   state_n = S_MAIN_G;
    endcase
  end

  // A request present on the CROSS_G entry edge survives the clear.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      veh_lat  <= 1'b0;
      ped_lat  <= 1'b0;
      ped_walk <= 1'b0;
      main_st  <= LAMP_G;
      cross_st <= LAMP_R;
    end else begin
      veh_lat  <= cross_req | (veh_lat & ~entering);
      ped_lat  <= ped_req   | (ped_lat & ~entering);
      if (entering)                  ped_walk <= ped_lat | ped_req;
      else if (state_n != S_CROSS_G) ped_walk <= 1'b0;
      {main_st, cross_st} <= lamps(state_n);
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Randomized and directed bench for intersection_scheduler against a
// tick-level behavioural model of the phase rules.
module tb_intersection_scheduler;
  import traffic_pkg::*;

  localparam int MIN_G = 15, MY = 3, CG = 10, CY = 3, AR = 1;

  logic       iClk = 1'b0;
  logic       iRstN = 1'b0;
  logic       tick = 1'b0, cross_req = 1'b0, ped_req = 1'b0, preempt = 1'b0;
  logic [2:0] main_st, cross_st, phase;
  logic       ped_walk, req_pending;

  int n_chk = 0, n_err = 0;

  // model: phase code, ticks spent in phase, request latches, walk lamp
  int   m_ph, m_el;
  logic m_veh, m_ped, m_walk;

  intersection_scheduler dut (
    .iClk(iClk), .iRstN(iRstN), .tick(tick), .cross_req(cross_req),
    .ped_req(ped_req), .preempt(preempt), .main_st(main_st),
    .cross_st(cross_st), .ped_walk(ped_walk), .phase(phase),
    .req_pending(req_pending)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk)
    if (iRstN) assert (main_st == 3'b100 || cross_st == 3'b100)
      else $error("both roads non-red: main=%b cross=%b", main_st, cross_st);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dur(input int ph);
    case (ph)
      0: return MIN_G;
      1: return MY;
      3: return CG;
      4: return CY;
      default: return AR;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int ph);
    return (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_cross(input int ph);
    return (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_veh = 0; m_ped = 0; m_walk = 0;
  endtask

  task automatic model_step(input logic cr, pr, pe, tk);
    int  nph;
    bit  done, enter;
    nph = m_ph;
    if (tk) begin
      done = (m_el + 1 >= dur(m_ph));
      case (m_ph)
        0: if (done && (m_veh || m_ped) && !pe) nph = 1;
        1: if (done) nph = 2;
        2: if (done) nph = pe ? 0 : 3;
        3: if (done || pe) nph = 4;
        4: if (done) nph = 5;
        default: if (done) nph = 0;
      endcase
      if (nph != m_ph) m_el = 0;
      else if (!(m_ph == 0 && done)) m_el++;
    end
    enter = (nph == 3) && (m_ph != 3);
    if (enter)         m_walk = m_ped | pr;
    else if (nph != 3) m_walk = 0;
    m_veh = cr | (m_veh & !enter);
    m_ped = pr | (m_ped & !enter);
    m_ph  = nph;
  endtask

  task automatic step(input logic cr, pr, pe, tk);
    cross_req = cr; ped_req = pr; preempt = pe; tick = tk;
    model_step(cr, pr, pe, tk);
    @(posedge iClk); #1;
    chk("phase", 8'(phase), 8'(m_ph));
    chk("main_st", 8'(main_st), 8'(exp_main(m_ph)));
    chk("cross_st", 8'(cross_st), 8'(exp_cross(m_ph)));
    chk("ped_walk", 8'(ped_walk), 8'(m_walk));
    chk("req_pending", 8'(req_pending), 8'(m_veh | m_ped));
  endtask

  // one idle cycle then one tick cycle, inputs held across both
  task automatic do_tick(input logic cr, pr, pe);
    step(cr, pr, pe, 1'b0);
    step(cr, pr, pe, 1'b1);
  endtask

  task automatic do_reset();
    iRstN = 1'b0;
    cross_req = 0; ped_req = 0; preempt = 0; tick = 0;
    #1;
    chk("rst_main", 8'(main_st), 8'h01);
    chk("rst_cross", 8'(cross_st), 8'h04);
    chk("rst_walk", 8'(ped_walk), 8'h00);
    chk("rst_phase", 8'(phase), 8'h00);
    chk("rst_pending", 8'(req_pending), 8'h00);
    #4 iRstN = 1'b1;
    model_reset();
  endtask

  initial begin
    logic cr, pr, pe;
    model_reset();
    @(posedge iClk); #1;
    do_reset();

    // idle: main rests green
    for (int t = 1; t <= 100; t++) do_tick(0, 0, 0);
    chk("idle_phase", 8'(phase), 8'h00);

    // vehicle request at tick 4
    do_reset();
    for (int t = 1; t <= 3; t++) do_tick(0, 0, 0);
    do_tick(1, 0, 0);
    for (int t = 5; t <= 33; t++) begin
      do_tick(0, 0, 0);
      case (t)
        14: chk("veh_t14", 8'(phase), 8'h00);
        15: chk("veh_t15", 8'(phase), 8'h01);
        18: chk("veh_t18", 8'(phase), 8'h02);
        19: chk("veh_t19", 8'(phase), 8'h03);
        29: chk("veh_t29", 8'(phase), 8'h04);
        32: chk("veh_t32", 8'(phase), 8'h05);
        33: chk("veh_t33", 8'(phase), 8'h00);
        default: ;
      endcase
    end

    // late ped press, preempt truncation, held preempt, clearance preempt
    do_reset();
    for (int t = 1; t <= 16; t++) do_tick(0, 0, 0);
    do_tick(0, 1, 0);
    chk("ped_t17", 8'(phase), 8'h01);
    for (int t = 18; t <= 21; t++) do_tick(0, 0, 0);
    chk("ped_cg", 8'(phase), 8'h03);
    chk("ped_walk_on", 8'(ped_walk), 8'h01);
    do_tick(0, 0, 0);
    do_tick(0, 0, 0);
    do_tick(1, 0, 1);
    chk("pre_cy", 8'(phase), 8'h04);
    chk("pre_walk_off", 8'(ped_walk), 8'h00);
    for (int t = 25; t <= 48; t++) do_tick(0, 0, 1);
    chk("pre_hold", 8'(phase), 8'h00);
    chk("pre_latched", 8'(req_pending), 8'h01);
    do_tick(0, 0, 0);
    chk("pre_release", 8'(phase), 8'h01);
    for (int t = 50; t <= 52; t++) do_tick(0, 0, 1);
    chk("clr_red_a", 8'(phase), 8'h02);
    do_tick(0, 0, 1);
    chk("clr_back", 8'(phase), 8'h00);
    chk("clr_latched", 8'(req_pending), 8'h01);
    for (int t = 54; t <= 67; t++) do_tick(0, 0, 0);
    chk("clr_t67", 8'(phase), 8'h00);
    for (int t = 68; t <= 74; t++) do_tick(0, 0, 0);
    chk("mid_cg", 8'(phase), 8'h03);
    do_reset();

    // illegal state code recovers to MAIN_G
    force dut.state = state_t'(3'd7);
    #1 release dut.state;
    chk("forced", 8'(phase), 8'h07);
    step(0, 0, 0, 0);
    chk("recover", 8'(phase), 8'h00);
    do_reset();

    // random traffic
    pe = 0;
    for (int i = 0; i < 6000; i++) begin
      cr = ($urandom_range(0, 29) == 0);
      pr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) pe = !pe;
      step(cr, pr, pe, ($urandom_range(0, 1) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
